// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch stage controller.
//   fetch_state_e    : FSM states of the instruction-memory read sequencer
//   NOP_INSTR        : encoding placed in IF/ID when it holds a bubble
//   DEFAULT_RESET_PC : PC value loaded by reset unless overridden
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // issue a read for the current PC
      S_WAIT = 2'd1,   // read outstanding, waiting for rvalid
      S_HOLD = 2'd2    // response buffered, waiting for decode to accept it
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage : fetch_pkg

// File: rtl/imem_resp_buf.sv
// ---------------------------------------------------------------------------
// imem_resp_buf
// Single-entry holding register for an instruction-memory response that
// arrived while decode was stalled.
// Ports:
//   clk      in          clock
//   rst      in          synchronous active-high reset (clears valid)
//   load_i   in          capture data_i and mark the entry valid
//   clear_i  in          drop the entry (consumed or flushed)
//   data_i   in  DATA_W  response data to capture
//   valid_o  out         entry holds a response
//   data_o   out DATA_W  buffered response data
// ---------------------------------------------------------------------------
module imem_resp_buf #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
      end
   end

   // NOTE: the data word has no reset; valid_q qualifies it, so resetting the
   // payload would only add reset fan-out with no functional effect.
   always_ff @(posedge clk) begin
      if (load_i) begin
         data_q <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : imem_resp_buf

// File: rtl/fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl
// Owns the PC and the IF/ID register, applies the hazard unit's PCwrite /
// Write_IFID / flush controls, and sequences instruction-memory reads over a
// one-outstanding req/rvalid handshake of variable latency (>= 1 cycle).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pc_write, write_ifid      hazard controls (0 = freeze PC / hold IF/ID)
//   flush, redirect_pc        squash IF/ID and redirect PC to redirect_pc
//   imem_req, imem_addr       one-cycle read request and its word address
//   imem_rvalid, imem_rdata   read response
//   ifid_valid, ifid_instr,
//   ifid_pc_plus1             IF/ID contents presented to decode
//   fetch_busy                no instruction ready to deliver this cycle
//   perf_stall, perf_flush    performance counters
// Build option: define FETCH_PERF_CNT_EN to build the performance counters;
// otherwise perf_stall/perf_flush are tied to zero.
// ---------------------------------------------------------------------------
module fetch_stage_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_write,
   input  logic              write_ifid,
   input  logic              flush,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              ifid_valid,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc_plus1,
   output logic              fetch_busy,
   output logic [31:0]       perf_stall,
   output logic [31:0]       perf_flush
);

   localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
   localparam logic [DATA_W-1:0] NOP      = DATA_W'(NOP_INSTR);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              drop_q, drop_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [ADDR_W-1:0] ifid_pcp1_q, ifid_pcp1_d;

   logic              buf_load, buf_clear, buf_valid;
   logic [DATA_W-1:0] buf_data;

   logic              advance;
   logic              deliver;
   logic [DATA_W-1:0] deliver_instr;

   // A mismatched pc_write/write_ifid pair never advances: it is a stall.
   assign advance = pc_write & write_ifid & ~flush;

   // Delivery comes either straight from a live response or from the buffer.
   assign deliver = advance &
                    (((state_q == S_WAIT) & imem_rvalid & ~drop_q) |
                     ((state_q == S_HOLD) & buf_valid));
   assign deliver_instr = (state_q == S_HOLD) ? buf_data : imem_rdata;

   imem_resp_buf #(.DATA_W(DATA_W)) u_resp_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .data_i  (imem_rdata),
      .valid_o (buf_valid),
      .data_o  (buf_data)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_d       = drop_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pcp1_d  = ifid_pcp1_q;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;

      unique case (state_q)
         S_REQ: begin
            state_d = S_WAIT;
            // The request leaving this cycle targets the pre-redirect PC.
            if (flush) drop_d = 1'b1;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (drop_q || flush) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else if (advance) begin
                  state_d = S_REQ;
               end else begin
                  buf_load = 1'b1;
                  state_d  = S_HOLD;
               end
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (flush || advance) begin
               buf_clear = 1'b1;
               state_d   = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      if (flush) begin
         pc_d         = redirect_pc;
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP;
      end else if (deliver) begin
         pc_d         = pc_q + PC_ONE;
         ifid_valid_d = 1'b1;
         ifid_instr_d = deliver_instr;
         ifid_pcp1_d  = pc_q + PC_ONE;
      end else if (advance) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= PC_RESET;
         drop_q       <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP;
         ifid_pcp1_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_q       <= drop_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pcp1_q  <= ifid_pcp1_d;
      end
   end

   // Requests and readiness are decoded from state; reset masks them so the
   // outputs read idle while rst is held.
   assign imem_req      = ~rst & (state_q == S_REQ);
   assign imem_addr     = pc_q;
   assign fetch_busy    = rst | (state_q == S_REQ) |
                          ((state_q == S_WAIT) & (~imem_rvalid | drop_q));
   assign ifid_valid    = ifid_valid_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc_plus1 = ifid_pcp1_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (!write_ifid) perf_stall_q <= perf_stall_q + 32'd1;
         if (flush)       perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`else
   assign perf_stall = '0;
   assign perf_flush = '0;
`endif

endmodule : fetch_stage_ctrl
